rx78_vram_ctl: RTL and testbench

CPU-side writer for the RX-78 bit-plane video memory and video registers. Decodes Z80 I/O writes to the plane-select, palette and layer-mask ports, and fans CPU memory writes in the $EC00–$FFFF window out to up to six VRAM planes, one plane per clock, stalling the CPU via wait. Sits between the Z80 bus and the VRAM write port. Its palette/mask register outputs feed the `gfx` renderer, which reads VRAM through its own port.

---
 rtl/rx78_vram_pkg.sv | 25 ++
 rtl/rx78_plane_pick.sv | 23 ++
 rtl/rx78_vram_ctl.sv | 194 +++++++++++++++++++
 tb/tb_rx78_vram_ctl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx78_vram_pkg.sv
// Shared constants and types for the RX-78 VRAM writer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rx78_vram_pkg;

  // Z80 I/O port map (port = cpu_addr[7:0])
  localparam logic [7:0] PORT_RDSEL  = 8'hF1;
  localparam logic [7:0] PORT_WRMASK = 8'hF2;
  localparam logic [7:0] PORT_PAL0   = 8'hF5;
  localparam logic [7:0] PORT_MASK   = 8'hFB;

  // Default plane window: $EC00..$FFFF, 5 KiB per plane
  localparam logic [15:0] VRAM_BASE_DFLT  = 16'hEC00;
  localparam logic [12:0] PLANE_SIZE_DFLT = 13'h1400;

  localparam int NUM_PLANES = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_t;

endpackage

// File: rtl/rx78_plane_pick.sv
// Lowest-set-bit encoder over the remaining plane mask.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the bit.
module rx78_plane_pick
  import rx78_vram_pkg::*;
(
  input  logic [NUM_PLANES-1:0] bits,
  output logic [2:0]            index,
  output logic [NUM_PLANES-1:0] rest
);

  // Scan downwards so the lowest set bit is the one that sticks
  always_comb begin
    index = 3'd0;
    for (int i = NUM_PLANES - 1; i >= 0; i--) begin
      if (bits[i]) index = i[2:0];
    end
  end

  // Clearing the lowest set bit is the classic x & (x-1)
  assign rest = bits & (bits - 6'd1);

endmodule

// File: rtl/rx78_vram_ctl.sv
// CPU-side writer for RX-78 bit-plane VRAM and video registers (macro RX78_VRAM_READBACK_EN adds readback).
// Latency: write fans out one plane per cycle starting the cycle after the strobe; readback takes 2 cycles.
// Backpressure: cpu_wait held while busy; mem strobes arriving when not idle are dropped.
module rx78_vram_ctl
  import rx78_vram_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE  = VRAM_BASE_DFLT,
  parameter logic [12:0] PLANE_SIZE = PLANE_SIZE_DFLT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_mem_wr,
  input  logic        cpu_mem_rd,
  input  logic        cpu_io_wr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  p1,
  output logic [7:0]  p2,
  output logic [7:0]  p3,
  output logic [7:0]  p4,
  output logic [7:0]  p5,
  output logic [7:0]  p6,
  output logic [7:0]  mask
);

  state_t                state;
  state_t                state_n;
  logic [2:0]            rd_sel;
  logic [NUM_PLANES-1:0] wr_mask;
  logic [NUM_PLANES-1:0] rem_q;
  logic [12:0]           off_q;
  logic [7:0]            data_q;
  logic [2:0]            pick_idx;
  logic [NUM_PLANES-1:0] pick_rest;
  logic                  in_win;
  logic [12:0]           offset;
  logic                  start_wr;
  logic                  start_rd;
  logic                  rd_req;

  // Window test done in 17 bits so BASE+SIZE may reach $10000 without wrapping
  assign in_win = ({1'b0, cpu_addr} >= {1'b0, VRAM_BASE}) &&
                  ({1'b0, cpu_addr} <  ({1'b0, VRAM_BASE} + {4'b0, PLANE_SIZE}));

  // Only the low 13 bits of addr-base matter inside the window
  assign offset = cpu_addr[12:0] - VRAM_BASE[12:0];

  rx78_plane_pick u_pick (
    .bits  (rem_q),
    .index (pick_idx),
    .rest  (pick_rest)
  );

  // I/O port decode; accepted in every state so the CPU can retune while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel  <= 3'd0;
      wr_mask <= '0;
      p1      <= 8'h00;
      p2      <= 8'h00;
      p3      <= 8'h00;
      p4      <= 8'h00;
      p5      <= 8'h00;
      p6      <= 8'h00;
      mask    <= 8'h00;
    end else if (cpu_io_wr) begin
      case (cpu_addr[7:0])
        PORT_RDSEL:          rd_sel  <= cpu_din[2:0];
        PORT_WRMASK:         wr_mask <= cpu_din[5:0];
        PORT_PAL0:           p1      <= cpu_din;
        PORT_PAL0 + 8'd1:    p2      <= cpu_din;
        PORT_PAL0 + 8'd2:    p3      <= cpu_din;
        PORT_PAL0 + 8'd3:    p4      <= cpu_din;
        PORT_PAL0 + 8'd4:    p5      <= cpu_din;
        PORT_PAL0 + 8'd5:    p6      <= cpu_din;
        PORT_MASK:           mask    <= cpu_din;
        default: ;
      endcase
    end
  end

`ifdef RX78_VRAM_READBACK_EN
  assign rd_req = cpu_mem_rd && in_win && !cpu_mem_wr;
`else
  assign rd_req = 1'b0;
`endif

  // Next-state: strobes only matter in IDLE; a zero write mask costs nothing
  always_comb begin
    state_n  = state;
    start_wr = 1'b0;
    start_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_mem_wr && in_win && (wr_mask != '0)) begin
          state_n  = ST_WRITE;
          start_wr = 1'b1;
        end else if (rd_req) begin
          state_n  = ST_RD_ADDR;
          start_rd = 1'b1;
        end
      end
      ST_WRITE: begin
        if (pick_rest == '0) state_n = ST_IDLE;
      end
      ST_RD_ADDR: state_n = ST_RD_DATA;
      ST_RD_DATA: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // State register; wait is registered from next-state so it tracks busy cycles exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cpu_wait <= 1'b0;
    end else begin
      state    <= state_n;
      cpu_wait <= (state_n != ST_IDLE);
    end
  end

  // Latch the mask at the strobe so later $F2 writes cannot disturb the fan-out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      off_q  <= 13'd0;
      data_q <= 8'h00;
    end else begin
      if (start_wr || start_rd) off_q <= offset;
      if (start_wr) begin
        rem_q  <= wr_mask;
        data_q <= cpu_din;
      end else if (state == ST_WRITE) begin
        rem_q  <= pick_rest;
      end
    end
  end

  assign vram_we    = (state == ST_WRITE);
  assign vram_wdata = data_q;

`ifdef RX78_VRAM_READBACK_EN
  logic [2:0] rd_plane_q;
  logic       rd_ok_q;

  // Capture plane choice at the read strobe; selects 0 and 7 name no plane
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_plane_q <= 3'd0;
      rd_ok_q    <= 1'b0;
    end else if (start_rd) begin
      rd_plane_q <= rd_sel - 3'd1;
      rd_ok_q    <= (rd_sel != 3'd0) && (rd_sel != 3'd7);
    end
  end

  // Readback data lands one cycle after the address phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout <= 8'hFF;
    end else if (state == ST_RD_DATA) begin
      cpu_dout <= rd_ok_q ? vram_rdata : 8'hFF;
    end
  end

  // VRAM address mux: fan-out plane, or read plane during the address phase
  always_comb begin
    vram_addr = 16'h0000;
    if (state == ST_WRITE) begin
      vram_addr = {pick_idx, off_q};
    end else if ((state == ST_RD_ADDR) && rd_ok_q) begin
      vram_addr = {rd_plane_q, off_q};
    end
  end
`else
  logic unused_rd_path;
  assign unused_rd_path = ^{cpu_mem_rd, vram_rdata, rd_sel};
  assign cpu_dout       = 8'hFF;

  // VRAM address mux: only the fan-out drives an address
  always_comb begin
    vram_addr = 16'h0000;
    if (state == ST_WRITE) vram_addr = {pick_idx, off_q};
  end
`endif

endmodule

// File: tb/tb_rx78_vram_ctl.sv
// Self-checking bench for rx78_vram_ctl: register table, fan-out, drop and reset sequences.
// Latency: stimulus changes on falling edges, outputs sampled on falling edges.
// Backpressure: bench honours wait by idling until each sequence completes.
module tb_rx78_vram_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_mem_wr;
  logic        cpu_mem_rd;
  logic        cpu_io_wr;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic [15:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;
  logic [7:0]  p1, p2, p3, p4, p5, p6, mask;

  int checks = 0;
  int errors = 0;

  logic        cap_we    [16];
  logic        cap_wait  [16];
  logic [15:0] cap_addr  [16];
  logic [7:0]  cap_wdata [16];
  logic [7:0]  cap_dout  [16];

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  din;
    logic [55:0] exp;   // {p1,p2,p3,p4,p5,p6,mask}
  } io_vec_t;

  io_vec_t vec [12];

  rx78_vram_ctl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_mem_wr (cpu_mem_wr),
    .cpu_mem_rd (cpu_mem_rd),
    .cpu_io_wr  (cpu_io_wr),
    .cpu_dout   (cpu_dout),
    .cpu_wait   (cpu_wait),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_rdata (vram_rdata),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .p6         (p6),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  // VRAM model: one known byte at plane 1 offset $13FF, 1-cycle read latency
  always @(posedge clk) vram_rdata <= (vram_addr == 16'h33FF) ? 8'h5A : 8'h00;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_din = d; cpu_io_wr = 1'b1;
    @(negedge clk);
    cpu_io_wr = 1'b0;
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_din = d; cpu_mem_wr = 1'b1;
    @(negedge clk);
    cpu_mem_wr = 1'b0;
  endtask

  task automatic mem_read(input logic [15:0] a);
    @(negedge clk);
    cpu_addr = a; cpu_mem_rd = 1'b1;
    @(negedge clk);
    cpu_mem_rd = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_we[i] = vram_we; cap_wait[i] = cpu_wait; cap_addr[i] = vram_addr;
      cap_wdata[i] = vram_wdata; cap_dout[i] = cpu_dout;
      @(negedge clk);
    end
  endtask

  function automatic int count_we(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_we[i]) c++;
    return c;
  endfunction

  function automatic int count_wait(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_wait[i]) c++;
    return c;
  endfunction

  initial begin
    logic [15:0] ea;
    logic [2:0]  pl;

    vec[0]  = '{16'h00F5, 8'h11, 56'h11_00_00_00_00_00_00};
    vec[1]  = '{16'h00F6, 8'h22, 56'h11_22_00_00_00_00_00};
    vec[2]  = '{16'h00F7, 8'h33, 56'h11_22_33_00_00_00_00};
    vec[3]  = '{16'h00F8, 8'h44, 56'h11_22_33_44_00_00_00};
    vec[4]  = '{16'h00F9, 8'h55, 56'h11_22_33_44_55_00_00};
    vec[5]  = '{16'h00FA, 8'h66, 56'h11_22_33_44_55_66_00};
    vec[6]  = '{16'h00FB, 8'h3F, 56'h11_22_33_44_55_66_3F};
    vec[7]  = '{16'h00F3, 8'hAA, 56'h11_22_33_44_55_66_3F};
    vec[8]  = '{16'h00F4, 8'hBB, 56'h11_22_33_44_55_66_3F};
    vec[9]  = '{16'h00FC, 8'hCC, 56'h11_22_33_44_55_66_3F};
    vec[10] = '{16'h00F0, 8'hDD, 56'h11_22_33_44_55_66_3F};
    vec[11] = '{16'hABF5, 8'h77, 56'h77_22_33_44_55_66_3F};

    reset_n = 1'b0; cpu_addr = 16'h0; cpu_din = 8'h0;
    cpu_mem_wr = 1'b0; cpu_mem_rd = 1'b0; cpu_io_wr = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset_regs", {8'h0, p1, p2, p3, p4, p5, p6, mask}, 64'h0);
    chk("reset_dout", cpu_dout, 8'hFF);
    chk("reset_wait", cpu_wait, 1'b0);
    chk("reset_we", vram_we, 1'b0);
    chk("reset_addr", vram_addr, 16'h0);
    chk("reset_wdata", vram_wdata, 8'h0);
    reset_n = 1'b1;

    // Register table
    for (int i = 0; i < 12; i++) begin
      io_write(vec[i].addr, vec[i].din);
      chk($sformatf("io_vec%0d", i), {8'h0, p1, p2, p3, p4, p5, p6, mask}, {8'h0, vec[i].exp});
    end

    // Three-plane fan-out
    io_write(16'h00F2, 8'h29);
    mem_write(16'hEC05, 8'hA5);
    capture(5);
    chk("fan3_we_cnt", count_we(5), 3);
    chk("fan3_wait_cnt", count_wait(5), 3);
    chk("fan3_addr0", {cap_we[0], cap_addr[0], cap_wdata[0]}, {1'b1, 16'h0005, 8'hA5});
    chk("fan3_addr1", {cap_we[1], cap_addr[1], cap_wdata[1]}, {1'b1, 16'h6005, 8'hA5});
    chk("fan3_addr2", {cap_we[2], cap_addr[2], cap_wdata[2]}, {1'b1, 16'hA005, 8'hA5});
    chk("fan3_wait_align", {cap_wait[0], cap_wait[1], cap_wait[2], cap_wait[3]}, 4'b1110);

    // Zero mask and out-of-window writes
    io_write(16'h00F2, 8'h00);
    mem_write(16'hF000, 8'h12);
    capture(4);
    chk("zero_mask_we", count_we(4), 0);
    chk("zero_mask_wait", count_wait(4), 0);
    io_write(16'h00F2, 8'h3F);
    mem_write(16'hEBFF, 8'h34);
    capture(4);
    chk("below_win_we", count_we(4), 0);
    chk("below_win_wait", count_wait(4), 0);

`ifdef RX78_VRAM_READBACK_EN
    io_write(16'h00F1, 8'h02);
    mem_read(16'hFFFF);
    capture(4);
    chk("rd_addr", cap_addr[0], 16'h33FF);
    chk("rd_wait_cnt", count_wait(4), 2);
    chk("rd_no_we", count_we(4), 0);
    chk("rd_dout", cap_dout[2], 8'h5A);
    io_write(16'h00F1, 8'h07);
    mem_read(16'hFFFF);
    capture(4);
    chk("rd7_wait_cnt", count_wait(4), 2);
    chk("rd7_dout", cap_dout[2], 8'hFF);
`else
    mem_read(16'hFFFF);
    capture(4);
    chk("rd_off_wait", count_wait(4), 0);
    chk("rd_off_dout", cpu_dout, 8'hFF);
`endif

    // Six-plane fan-out with a mask rewrite and a second write mid-flight
    mem_write(16'hEC10, 8'hC3);
    for (int c = 0; c < 9; c++) begin
      cap_we[c] = vram_we; cap_wait[c] = cpu_wait;
      cap_addr[c] = vram_addr; cap_wdata[c] = vram_wdata;
      if (c == 1) begin
        cpu_addr = 16'h00F2; cpu_din = 8'h02; cpu_io_wr = 1'b1;
      end else if (c == 2) begin
        cpu_io_wr = 1'b0; cpu_addr = 16'hEC20; cpu_din = 8'h99; cpu_mem_wr = 1'b1;
      end else if (c == 3) begin
        cpu_mem_wr = 1'b0;
      end
      @(negedge clk);
    end
    chk("ovl_we_cnt", count_we(9), 6);
    chk("ovl_wait_cnt", count_wait(9), 6);
    for (int c = 0; c < 6; c++) begin
      pl = c[2:0];
      ea = {pl, 13'h0010};
      chk($sformatf("ovl_plane%0d", c), {cap_we[c], cap_addr[c], cap_wdata[c]}, {1'b1, ea, 8'hC3});
    end
    mem_write(16'hEC30, 8'h5E);
    capture(3);
    chk("newmask_we_cnt", count_we(3), 1);
    chk("newmask_beat", {cap_addr[0], cap_wdata[0]}, {16'h2030, 8'h5E});

    // Reset in the third cycle of a six-plane fan-out
    io_write(16'h00F2, 8'h3F);
    mem_write(16'hEC00, 8'h77);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_beat", {vram_we, vram_addr}, {1'b1, 16'h4000});
    reset_n = 1'b0;
    #1;
    chk("rst_we", vram_we, 1'b0);
    chk("rst_wait", cpu_wait, 1'b0);
    chk("rst_regs", {8'h0, p1, p2, p3, p4, p5, p6, mask}, 64'h0);
    chk("rst_addr_data", {vram_addr, vram_wdata, cpu_dout}, {16'h0, 8'h0, 8'hFF});
    @(negedge clk);
    reset_n = 1'b1;
    mem_write(16'hEC00, 8'h11);
    capture(4);
    chk("post_rst_we", count_we(4), 0);
    chk("post_rst_wait", count_wait(4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
